// File: rtl/pipe_reg_packer.sv
// pipe_reg_packer
// Decode/register-read -> execute pipeline register. It packs
// {inst, a_data, b_data, control_data, alucontrol_data, pc} into one bundle
// and holds it behind a valid/ready handshake.
// Whenever out_valid is low, out_bundle reads as zero (a NOP bubble).
// Optional feature: define PIPE_REG_SKID_EN to add one skid entry.
//   Enabled:  in_ready is a flop output, and capacity is 2.
//   Disabled: in_ready is combinational from out_ready, and capacity is 1.

module pipe_reg_packer #(
    parameter int INST_W    = 32,
    parameter int DATA_W    = 32,
    parameter int CTRL_W    = 54,
    parameter int ALUCTRL_W = 38,
    parameter int PC_W      = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INST_W-1:0]    inst,
    input  logic [DATA_W-1:0]    a_data,
    input  logic [DATA_W-1:0]    b_data,
    input  logic [CTRL_W-1:0]    control_data,
    input  logic [ALUCTRL_W-1:0] alucontrol_data,
    input  logic [PC_W-1:0]      pc,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INST_W+2*DATA_W+CTRL_W+ALUCTRL_W+PC_W-1:0] out_bundle
);

    localparam int BUNDLE_W = INST_W + 2*DATA_W + CTRL_W + ALUCTRL_W + PC_W;

    logic [BUNDLE_W-1:0] w_in_bundle;
    logic                w_accept;
    logic                w_consume;

    logic                r_valid;
    logic [BUNDLE_W-1:0] r_bundle;

    // Pure concatenation: inst lands in the MSBs and pc in the LSBs.
    assign w_in_bundle = {inst, a_data, b_data, control_data, alucontrol_data, pc};

    // A flush cycle never accepts, so the bundle offered in that cycle is dropped.
    assign w_accept  = in_valid && in_ready && !flush;
    assign w_consume = r_valid && out_ready;

    assign out_valid  = r_valid;
    assign out_bundle = r_bundle;

`ifdef PIPE_REG_SKID_EN

    logic                r_skid_valid;
    logic [BUNDLE_W-1:0] r_skid_bundle;

    // in_ready depends only on a flop, so it does not see out_ready in the same cycle.
    assign in_ready = !r_skid_valid;

    // Main register: refills from the skid entry first, so ordering stays FIFO.
    // The skid entry can only be occupied while main is full.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid  <= 1'b0;
            r_bundle <= '0;
        end else if (flush) begin
            r_valid  <= 1'b0;
            r_bundle <= '0;
        end else if (!r_valid || w_consume) begin
            if (r_skid_valid) begin
                r_valid  <= 1'b1;
                r_bundle <= r_skid_bundle;
            end else if (w_accept) begin
                r_valid  <= 1'b1;
                r_bundle <= w_in_bundle;
            end else begin
                r_valid  <= 1'b0;
                r_bundle <= '0;
            end
        end
    end

    // Skid entry: captures an accept while main is stalled.
    // It empties when its contents move into main.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_skid_valid  <= 1'b0;
            r_skid_bundle <= '0;
        end else if (flush) begin
            r_skid_valid  <= 1'b0;
            r_skid_bundle <= '0;
        end else if (r_valid && !w_consume && w_accept) begin
            r_skid_valid  <= 1'b1;
            r_skid_bundle <= w_in_bundle;
        end else if (w_consume) begin
            r_skid_valid  <= 1'b0;
            r_skid_bundle <= '0;
        end
    end

`else

    // Single entry: accept is possible when the register is empty or drains this cycle.
    assign in_ready = !r_valid || out_ready;

    // Main register: load on accept, zero to a bubble on a bare consume, clear on flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid  <= 1'b0;
            r_bundle <= '0;
        end else if (flush) begin
            r_valid  <= 1'b0;
            r_bundle <= '0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_bundle <= w_in_bundle;
        end else if (w_consume) begin
            r_valid  <= 1'b0;
            r_bundle <= '0;
        end
    end

`endif

endmodule

// File: doc/pipe_reg_packer.md
# pipe_reg_packer

Pipeline-stage register that assembles the per-instruction bundle consumed by the downstream stage interpreter. It captures instruction word, operand A/B data, main-decoder control word, ALU-decoder control word and PC into a single 220-bit bundle. The bundle is held behind a valid/ready handshake with stall back-pressure and flush-to-bubble. It sits between decode/register-read and execute.

## Interface
- `INST_W`, 32, instruction field width
- `DATA_W`, 32, width of each operand field (A, B)
- `CTRL_W`, 54, main-decoder control field width
- `ALUCTRL_W`, 38, ALU-decoder control field width
- `PC_W`, 32, PC field width
- `BUNDLE_W`, derived = INST_W+2·DATA_W+CTRL_W+ALUCTRL_W+PC_W (220); not overridable
- `clk`  in  1  clock; all state updates on rising edge
- `resetn`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  upstream presents a bundle
- `in_ready`  out  1  block accepts this cycle
- `inst`  in  INST_W  instruction word
- `a_data`  in  DATA_W  operand A
- `b_data`  in  DATA_W  operand B
- `control_data`  in  CTRL_W  main-decoder control word, opaque
- `alucontrol_data`  in  ALUCTRL_W  ALU-decoder control word, opaque
- `pc`  in  PC_W  instruction PC
- `flush`  in  1  discard all held and incoming bundles
- `out_valid`  out  1  `out_bundle` holds a live instruction
- `out_ready`  in  1  downstream consumes this cycle
- `out_bundle`  out  BUNDLE_W  {inst, a_data, b_data, control_data, alucontrol_data, pc}, inst in MSBs, pc in LSBs

## Operation
- Accept = `in_valid && in_ready && !flush`; consume = `out_valid && out_ready`.
- Main register (`out_bundle`, `out_valid`) loads on accept when empty or consuming in same cycle; otherwise holds.
- Consume without accept: `out_valid` -> 0; `out_bundle` is forced to all-zero (bubble: inst 0 = NOP, all control bits 0, no reg/mem write).
- Bubble contents: whenever `out_valid`=0, `out_bundle` = 0. Verification checks this invariant every cycle.
- `flush`: next cycle `out_valid`=0, `out_bundle`=0, skid entry (if present) invalidated. Flush overrides simultaneous accept and consume; the input offered in the flush cycle is dropped.
- Field packing is a pure concatenation; no field is modified except zeroing for bubbles.

## Timing
- Reset (async assert): `out_valid`=0, `out_bundle`=0, `in_ready`=1, skid empty. Deassertion is synchronised externally; first accept may occur on the first edge after release.
- Latency: accepted bundle appears on `out_bundle` with `out_valid`=1 one cycle after accept.
- Throughput: one bundle per cycle while `out_ready`=1.
- Stall: `out_valid`=1 and `out_ready`=0 holds `out_bundle` bit-stable until consumed or flushed.
- Upstream must hold `in_valid` and data stable until accepted; `in_valid` may not depend combinationally on `in_ready`.

## Configuration
- `PIPE_REG_SKID_EN` defined: adds one skid entry; `in_ready` is a flop output (= skid empty). When main is full and not consumed, an accepted bundle goes to skid; `in_ready` drops next cycle. On consume, skid moves to main and `in_ready` rises next cycle. Order is strictly FIFO; capacity 2.
- Not defined: no skid; `in_ready` = `!out_valid || out_ready` (combinational from `out_ready`); capacity 1.

## Test plan
- Reset mid-stream: `out_valid`=1 with bundle pc=0x00400010, pull `resetn` low between edges -> `out_valid`=0, `out_bundle`=0 immediately, `in_ready`=1.
- Streaming: 4 back-to-back accepts (pc 0x00400000..0x0040000C), `out_ready`=1 -> outputs in order, one per cycle, first one cycle after accept; inst field = bits 219:188, pc = bits 31:0.
- Stall: `out_ready`=0 for 3 cycles holding pc=0x00400020 -> `out_bundle` unchanged; without macro `in_ready`=0; with macro second bundle (pc 0x00400024) accepted into skid, then `in_ready`=0; after release both emerge in order.
- Flush with simultaneous accept and consume: `flush`=1, `in_valid`=1, `out_ready`=1 -> next cycle `out_valid`=0, `out_bundle`=0, offered bundle never appears, skid empty.
- Drain to bubble: single bundle consumed with `in_valid`=0 -> next cycle `out_valid`=0 and `out_bundle`=0.
- Random valid/ready/flush, 10k cycles, both configurations -> scoreboard: no loss, no duplication, order preserved, bubble invariant holds.
